// File: rtl/alu_writeback_pkg.sv
// alu_writeback_pkg: shared destination and state types for the ALU commit stage
package alu_writeback_pkg;
  typedef enum logic [2:0] {DEST_NONE, DEST_A, DEST_B, DEST_MX, DEST_MY} wb_dest_t;
  typedef enum logic [1:0] {IDLE, MEM_WRITE, PTR_UPDATE, DONE} wb_state_t;
endpackage

// File: rtl/alu_writeback_flag_register.sv
// alu_writeback_flag_register: C/Z/D/I storage, commit updates override direct writes
module alu_writeback_flag_register (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flag_we,
  input  logic [3:0] flag_wdata,
  input  logic       commit,
  input  logic       update_carry,
  input  logic       update_zero,
  input  logic       alu_carry,
  input  logic       alu_zero,
  output logic       flag_carry,
  output logic       flag_zero,
  output logic       flag_decimal,
  output logic       flag_interrupt
);
  always_ff @(posedge clk)
    if (!reset_n) begin
      flag_carry     <= 1'b0;
      flag_zero      <= 1'b0;
      flag_decimal   <= 1'b0;
      flag_interrupt <= 1'b0;
    end else begin
      flag_carry     <= (commit && update_carry) ? alu_carry : flag_we ? flag_wdata[0] : flag_carry;
      flag_zero      <= (commit && update_zero) ? alu_zero : flag_we ? flag_wdata[1] : flag_zero;
      flag_decimal   <= flag_we ? flag_wdata[2] : flag_decimal;
      flag_interrupt <= flag_we ? flag_wdata[3] : flag_interrupt;
    end
endmodule

// File: rtl/alu_writeback.sv
// alu_writeback: commits ALU results to flags, A/B registers or memory with pointer post-increment
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clk_en,
  input  logic              start,
  input  logic [2:0]        dest,
  input  logic [3:0]        result,
  input  logic              alu_carry,
  input  logic              alu_zero,
  input  logic              update_carry,
  input  logic              update_zero,
  input  logic              ptr_inc,
  input  logic [ADDR_W-1:0] x_ptr,
  input  logic [ADDR_W-1:0] y_ptr,
  input  logic              flag_we,
  input  logic [3:0]        flag_wdata,
  output logic [3:0]        reg_a,
  output logic [3:0]        reg_b,
  output logic              flag_carry,
  output logic              flag_zero,
  output logic              flag_decimal,
  output logic              flag_interrupt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wdata,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic              ptr_update_x,
  output logic              ptr_update_y,
  output logic [ADDR_W-1:0] ptr_next,
  output logic              busy,
  output logic              done
);
  wb_state_t  state;
  logic [2:0] dest_q;
  logic       inc_q;
  logic       accept;
  logic       is_mem;
  assign accept = clk_en && start && state == IDLE;
  assign is_mem = dest == DEST_MX || dest == DEST_MY;
  assign busy   = state != IDLE;
  assign done   = state == DONE;
  alu_writeback_flag_register u_flags (
    .clk           (clk),
    .reset_n       (reset_n),
    .flag_we       (flag_we && clk_en),
    .flag_wdata    (flag_wdata),
    .commit        (accept),
    .update_carry  (update_carry),
    .update_zero   (update_zero),
    .alu_carry     (alu_carry),
    .alu_zero      (alu_zero),
    .flag_carry    (flag_carry),
    .flag_zero     (flag_zero),
    .flag_decimal  (flag_decimal),
    .flag_interrupt(flag_interrupt)
  );
  always_ff @(posedge clk)
    if (!reset_n) begin
      state        <= IDLE;
      dest_q       <= 3'd0;
      inc_q        <= 1'b0;
      reg_a        <= 4'd0;
      reg_b        <= 4'd0;
      mem_addr     <= '0;
      mem_wdata    <= 4'd0;
      mem_we       <= 1'b0;
      ptr_next     <= '0;
      ptr_update_x <= 1'b0;
      ptr_update_y <= 1'b0;
    end else begin
      ptr_update_x <= 1'b0;
      ptr_update_y <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          dest_q <= dest;
          inc_q  <= ptr_inc;
          if (dest == DEST_A) reg_a <= result;
          if (dest == DEST_B) reg_b <= result;
          if (is_mem) begin
            mem_addr  <= dest == DEST_MX ? x_ptr : y_ptr;
            mem_wdata <= result;
            mem_we    <= 1'b1;
            state     <= MEM_WRITE;
          end else state <= DONE;
        end
        MEM_WRITE: if (mem_ack) begin
          mem_we <= 1'b0;
          if (inc_q) begin
            // mem_addr still holds the pointer used; only the low byte advances
            ptr_next     <= {mem_addr[ADDR_W-1:8], mem_addr[7:0] + 8'd1};
            ptr_update_x <= dest_q == DEST_MX;
            ptr_update_y <= dest_q == DEST_MY;
            state        <= PTR_UPDATE;
          end else state <= DONE;
        end
        PTR_UPDATE: state <= DONE;
        default:    state <= IDLE;
      endcase
    end
endmodule
